// File: rtl/video_stream_monitor.sv
// Passive de/hs/vs stream monitor: measures per-frame width, height and per-channel checksums,
// and flags sync, line-length, geometry and counter-overflow errors. Results pulse out once per frame.
module video_stream_monitor #(
    parameter int CH_COUNT = 1,
    parameter int CH_WIDTH = 8,
    parameter int CNT_W    = 12,
    parameter int SUM_W    = 32,
    parameter int FRCNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_COUNT*CH_WIDTH-1:0] di_i,
    input  logic                         de_i,
    input  logic                         hs_i,
    input  logic                         vs_i,
    input  logic                         chk_en_i,
    input  logic [CNT_W-1:0]             exp_w_i,
    input  logic [CNT_W-1:0]             exp_h_i,
    output logic                         stat_vld_o,
    output logic [CNT_W-1:0]             stat_w_o,
    output logic [CNT_W-1:0]             stat_h_o,
    output logic [CH_COUNT*SUM_W-1:0]    stat_sum_o,
    output logic [3:0]                   stat_err_o,
    output logic [FRCNT_W-1:0]           frcnt_o
);

    localparam int               DI_W    = CH_COUNT * CH_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        CLOSE    = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DI_W-1:0] di_r, ev_di;
    logic            de_r, hs_r, vs_r;
    logic            de_p, hs_p, vs_p;
    logic            vs_rise;
    logic            ev_pix, ev_sync, ev_line, ev_hs_rise, ev_vs_rise;

    assign vs_rise = vs_r & ~vs_p;

    // Stage 1 registers the raw inputs; stage 2 turns them into per-cycle events for the FSM.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            di_r       <= '0;
            de_r       <= 1'b0;
            hs_r       <= 1'b0;
            vs_r       <= 1'b0;
            de_p       <= 1'b0;
            hs_p       <= 1'b0;
            vs_p       <= 1'b0;
            ev_di      <= '0;
            ev_pix     <= 1'b0;
            ev_sync    <= 1'b0;
            ev_line    <= 1'b0;
            ev_hs_rise <= 1'b0;
            ev_vs_rise <= 1'b0;
        end else begin
            di_r       <= di_i;
            de_r       <= de_i;
            hs_r       <= hs_i;
            vs_r       <= vs_i;
            de_p       <= de_r;
            hs_p       <= hs_r;
            vs_p       <= vs_r;
            ev_di      <= di_r;
            ev_pix     <= de_r & ~hs_r & ~vs_r;
            ev_sync    <= de_r & (hs_r | vs_r);
            // A de run still open at the vs edge is closed as a line in the same event.
            ev_line    <= de_p & (~de_r | vs_rise);
            ev_hs_rise <= hs_r & ~hs_p;
            ev_vs_rise <= vs_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_SOF;
        else        state <= state_nx;
    end

    // NOTE: next-state gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_SOF: if (ev_vs_rise) state_nx = ACTIVE;
            ACTIVE:   if (ev_vs_rise) state_nx = CLOSE;
            CLOSE:    state_nx = ACTIVE;
            default:  state_nx = WAIT_SOF;
        endcase
    end

    logic [CNT_W-1:0]               pix_cnt, line_cnt, width;
    logic [CH_COUNT-1:0][SUM_W-1:0] sum_q;
    logic                           sync_err, len_err, ovf_err;
    logic                           geom_err;
    logic                           clr_work;

    assign clr_work = (state == WAIT_SOF && ev_vs_rise) || (state == CLOSE);
    assign geom_err = chk_en_i && ((width != exp_w_i) || (line_cnt != exp_h_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            width    <= '0;
            sum_q    <= '0;
            sync_err <= 1'b0;
            len_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (clr_work) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            width    <= '0;
            sum_q    <= '0;
            sync_err <= 1'b0;
            len_err  <= 1'b0;
            ovf_err  <= 1'b0;
        end else if (state == ACTIVE) begin
            if (ev_sync) sync_err <= 1'b1;

            // Line end and hs edge never coincide with an accepted pixel, so priority here is safe.
            if (ev_line || ev_hs_rise) begin
                pix_cnt <= '0;
            end else if (ev_pix) begin
                if (pix_cnt == CNT_MAX) ovf_err <= 1'b1;
                else                    pix_cnt <= pix_cnt + CNT_W'(1);
            end

            if (ev_pix) begin
                for (int k = 0; k < CH_COUNT; k++) begin
                    sum_q[k] <= sum_q[k] + SUM_W'(ev_di[k*CH_WIDTH +: CH_WIDTH]);
                end
            end

            if (ev_line) begin
                if (line_cnt == CNT_MAX) ovf_err  <= 1'b1;
                else                     line_cnt <= line_cnt + CNT_W'(1);
                if (line_cnt == '0)         width   <= pix_cnt;
                else if (pix_cnt != width)  len_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_vld_o <= 1'b0;
            stat_w_o   <= '0;
            stat_h_o   <= '0;
            stat_sum_o <= '0;
            stat_err_o <= '0;
            frcnt_o    <= '0;
        end else begin
            stat_vld_o <= (state == CLOSE);
            if (state == CLOSE) begin
                stat_w_o   <= width;
                stat_h_o   <= line_cnt;
                stat_sum_o <= sum_q;
                stat_err_o <= {ovf_err, geom_err, len_err, sync_err};
                frcnt_o    <= frcnt_o + FRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_video_stream_monitor.sv
// Bench for video_stream_monitor: three instances (default, 3-channel, 3-bit counters) share one
// stream; results are checked against a directed table and a frame-level reference model.
module tb_video_stream_monitor;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] di;
    logic        de, hs, vs, chk_en;
    logic [11:0] exp_w, exp_h;

    logic        v1, v3, vsm;
    logic [11:0] w1, h1, w3, h3;
    logic [2:0]  wsm, hsm;
    logic [31:0] sum1, sumsm;
    logic [95:0] sum3;
    logic [3:0]  err1, err3, errsm;
    logic [15:0] fr1, fr3, frsm;

    video_stream_monitor u1 (
        .clk(clk), .rst_n(rst_n), .di_i(di[7:0]), .de_i(de), .hs_i(hs), .vs_i(vs),
        .chk_en_i(chk_en), .exp_w_i(exp_w), .exp_h_i(exp_h),
        .stat_vld_o(v1), .stat_w_o(w1), .stat_h_o(h1), .stat_sum_o(sum1),
        .stat_err_o(err1), .frcnt_o(fr1)
    );

    video_stream_monitor #(.CH_COUNT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
        .chk_en_i(chk_en), .exp_w_i(exp_w), .exp_h_i(exp_h),
        .stat_vld_o(v3), .stat_w_o(w3), .stat_h_o(h3), .stat_sum_o(sum3),
        .stat_err_o(err3), .frcnt_o(fr3)
    );

    video_stream_monitor #(.CNT_W(3)) usm (
        .clk(clk), .rst_n(rst_n), .di_i(di[7:0]), .de_i(de), .hs_i(hs), .vs_i(vs),
        .chk_en_i(chk_en), .exp_w_i(exp_w[2:0]), .exp_h_i(exp_h[2:0]),
        .stat_vld_o(vsm), .stat_w_o(wsm), .stat_h_o(hsm), .stat_sum_o(sumsm),
        .stat_err_o(errsm), .frcnt_o(frsm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame description: line lengths as 4-bit nibbles (line 0 in the low nibble), a bad-start
    // flag per line (de together with hs), data mode, geometry check inputs, and the expected
    // default-instance results used for the directed entries.
    typedef struct packed {
        int          nlines;
        logic [47:0] lens;
        logic [11:0] bad;
        logic [1:0]  mode;   // 0: pixel index, 1: channel k carries k+1, 2: random
        logic        chk;
        logic [11:0] ew, eh;
        logic [11:0] xw, xh;
        logic [31:0] xsum;
        logic [3:0]  xerr;
    } vec_t;

    typedef struct {
        int     w, h, err, fr;
        longint s0, s1, s2;
    } exp_t;

    exp_t   q1[$], q3[$], qsm[$];
    exp_t   e1, e3, esm;
    longint sacc[3];
    int     fr_n   = 0;
    int     vs_cyc = 0;
    int     n_total = 0;
    int     n_bad   = 0;
    vec_t   vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Frame-level reference: results follow from the line lengths alone, with counts clipped
    // at the counter maximum.
    function automatic exp_t model(input vec_t f, input int cnt_w);
        exp_t e;
        int   mx, c;
        bit   sync, len, geom, ovf;
        mx = (1 << cnt_w) - 1;
        e.w = 0; sync = 0; len = 0; ovf = 0;
        for (int i = 0; i < f.nlines; i++) begin
            c = int'(f.lens[i*4 +: 4]);
            if (c > mx) begin c = mx; ovf = 1; end
            if (f.bad[i]) sync = 1;
            if (i == 0) e.w = c;
            else if (c != e.w) len = 1;
        end
        e.h = f.nlines;
        if (e.h > mx) begin e.h = mx; ovf = 1; end
        geom  = f.chk && ((e.w != (int'(f.ew) & mx)) || (e.h != (int'(f.eh) & mx)));
        e.err = int'(sync) + 2 * int'(len) + 4 * int'(geom) + 8 * int'(ovf);
        e.fr  = fr_n;
        e.s0  = sacc[0] & 64'hFFFF_FFFF;
        e.s1  = sacc[1] & 64'hFFFF_FFFF;
        e.s2  = sacc[2] & 64'hFFFF_FFFF;
        return e;
    endfunction

    task automatic drive_vs();
        int n;
        n = $urandom_range(1, 3);
        @(negedge clk);
        vs_cyc = cyc + 1;
        vs = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drive_lines(input vec_t f);
        int         idx, len;
        logic [7:0] v;
        idx = 0;
        for (int k = 0; k < 3; k++) sacc[k] = 0;
        for (int i = 0; i < f.nlines; i++) begin
            len = int'(f.lens[i*4 +: 4]);
            if (f.bad[i]) begin
                @(negedge clk); de = 1'b1; hs = 1'b1; di = 24'($urandom);
            end
            for (int j = 0; j < len; j++) begin
                @(negedge clk); de = 1'b1; hs = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    case (f.mode)
                        2'd0:    v = 8'(idx);
                        2'd1:    v = 8'(k + 1);
                        default: v = 8'($urandom);
                    endcase
                    di[k*8 +: 8] = v;
                    sacc[k] += longint'(v);
                end
                idx++;
            end
            @(negedge clk); de = 1'b0; hs = 1'b0;
            if (!f.bad[i]) begin
                @(negedge clk); hs = 1'b1;
                @(negedge clk); hs = 1'b0;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic finish_frame(input vec_t f, input bit directed);
        exp_t e;
        chk_en = f.chk;
        exp_w  = f.ew;
        exp_h  = f.eh;
        fr_n++;
        e = model(f, 12);
        if (directed) begin
            e.w   = int'(f.xw);
            e.h   = int'(f.xh);
            e.s0  = longint'(f.xsum);
            e.err = int'(f.xerr);
        end
        q1.push_back(e);
        q3.push_back(model(f, 12));
        qsm.push_back(model(f, 3));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (v1) begin
                check("u1 frame pending", 64'(q1.size() > 0), 64'd1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("u1 latency", 64'(cyc - vs_cyc), 64'd3);
                    check("u1 width", 64'(w1), 64'(e1.w));
                    check("u1 height", 64'(h1), 64'(e1.h));
                    check("u1 sum", 64'(sum1), 64'(e1.s0));
                    check("u1 err", 64'(err1), 64'(e1.err));
                    check("u1 frcnt", 64'(fr1), 64'(e1.fr));
                end
            end
            if (v3) begin
                check("u3 frame pending", 64'(q3.size() > 0), 64'd1);
                if (q3.size() > 0) begin
                    e3 = q3.pop_front();
                    check("u3 width", 64'(w3), 64'(e3.w));
                    check("u3 height", 64'(h3), 64'(e3.h));
                    check("u3 sum ch0", 64'(sum3[31:0]), 64'(e3.s0));
                    check("u3 sum ch1", 64'(sum3[63:32]), 64'(e3.s1));
                    check("u3 sum ch2", 64'(sum3[95:64]), 64'(e3.s2));
                    check("u3 err", 64'(err3), 64'(e3.err));
                    check("u3 frcnt", 64'(fr3), 64'(e3.fr));
                end
            end
            if (vsm) begin
                check("usm frame pending", 64'(qsm.size() > 0), 64'd1);
                if (qsm.size() > 0) begin
                    esm = qsm.pop_front();
                    check("usm width", 64'(wsm), 64'(esm.w));
                    check("usm height", 64'(hsm), 64'(esm.h));
                    check("usm sum", 64'(sumsm), 64'(esm.s0));
                    check("usm err", 64'(errsm), 64'(esm.err));
                    check("usm frcnt", 64'(frsm), 64'(esm.fr));
                end
            end
        end
    end

    initial begin
        vec_t f;
        de = 1'b0; hs = 1'b0; vs = 1'b0; di = '0;
        chk_en = 1'b0; exp_w = '0; exp_h = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst vld", 64'(v1), 64'd0);
        check("rst width", 64'(w1), 64'd0);
        check("rst height", 64'(h1), 64'd0);
        check("rst sum", 64'(sum1), 64'd0);
        check("rst err", 64'(err1), 64'd0);
        check("rst frcnt", 64'(fr1), 64'd0);
        check("rst u3 sum", 64'(sum3[63:0]), 64'd0);
        check("rst usm frcnt", 64'(frsm), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{nlines: 3, lens: 48'h444, bad: 12'h0, mode: 2'd0, chk: 1'b1, ew: 12'd4,  eh: 12'd3,
                    xw: 12'd4,  xh: 12'd3, xsum: 32'd66,  xerr: 4'd0};
        vecs[1] = '{nlines: 2, lens: 48'h22,  bad: 12'h0, mode: 2'd1, chk: 1'b1, ew: 12'd2,  eh: 12'd2,
                    xw: 12'd2,  xh: 12'd2, xsum: 32'd4,   xerr: 4'd0};
        vecs[2] = '{nlines: 3, lens: 48'h544, bad: 12'h0, mode: 2'd0, chk: 1'b0, ew: 12'd0,  eh: 12'd0,
                    xw: 12'd4,  xh: 12'd3, xsum: 32'd78,  xerr: 4'd2};
        vecs[3] = vecs[0];
        vecs[4] = '{nlines: 2, lens: 48'h33,  bad: 12'h1, mode: 2'd0, chk: 1'b0, ew: 12'd0,  eh: 12'd0,
                    xw: 12'd3,  xh: 12'd2, xsum: 32'd15,  xerr: 4'd1};
        vecs[5] = '{nlines: 3, lens: 48'hAAA, bad: 12'h0, mode: 2'd0, chk: 1'b1, ew: 12'd10, eh: 12'd5,
                    xw: 12'd10, xh: 12'd3, xsum: 32'd435, xerr: 4'd4};
        vecs[6] = '{nlines: 0, lens: 48'h0,   bad: 12'h0, mode: 2'd0, chk: 1'b1, ew: 12'd0,  eh: 12'd0,
                    xw: 12'd0,  xh: 12'd0, xsum: 32'd0,   xerr: 4'd0};
        vecs[7] = '{nlines: 0, lens: 48'h0,   bad: 12'h0, mode: 2'd0, chk: 1'b1, ew: 12'd4,  eh: 12'd3,
                    xw: 12'd0,  xh: 12'd0, xsum: 32'd0,   xerr: 4'd4};

        for (int i = 0; i < 8; i++) begin
            drive_vs();
            drive_lines(vecs[i]);
            finish_frame(vecs[i], 1'b1);
        end

        for (int n = 0; n < 20; n++) begin
            f = '0;
            f.nlines = $urandom_range(0, 9);
            for (int i = 0; i < f.nlines; i++) begin
                f.lens[i*4 +: 4] = 4'($urandom_range(1, 10));
                f.bad[i]         = ($urandom_range(0, 4) == 0);
            end
            f.mode = 2'd2;
            f.chk  = 1'($urandom_range(0, 1));
            f.ew   = (f.nlines > 0) ? 12'(f.lens[3:0]) : 12'd0;
            f.eh   = 12'(f.nlines);
            if ($urandom_range(0, 3) == 0) f.eh = f.eh + 12'd1;
            drive_vs();
            drive_lines(f);
            finish_frame(f, 1'b0);
        end

        // Reset in the middle of a frame, then a discarded partial frame and one reported frame.
        drive_vs();
        drive_lines(vecs[0]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst frcnt", 64'(fr1), 64'd0);
        check("midrst width", 64'(w1), 64'd0);
        check("midrst sum", 64'(sum1), 64'd0);
        check("midrst usm frcnt", 64'(frsm), 64'd0);
        check("midrst queue drained", 64'(q1.size()), 64'd0);
        q1.delete(); q3.delete(); qsm.delete();
        fr_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive_lines(vecs[1]);
        drive_vs();
        drive_lines(vecs[2]);
        finish_frame(vecs[2], 1'b1);
        drive_vs();
        repeat (8) @(negedge clk);

        check("final u1 queue", 64'(q1.size()), 64'd0);
        check("final u3 queue", 64'(q3.size()), 64'd0);
        check("final usm queue", 64'(qsm.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
